// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce.
//   Drives one column low at a time (col, active-low one-hot), samples the
//   active-low rows through a 2-flop synchronizer, and debounces both the
//   press and the release of the first key found.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   row[3:0]  - keypad rows, active-low, asynchronous to clk
//   col[3:0]  - column drive, active-low one-hot
//   key_code  - {row_idx, col_idx} of the last accepted key
//   key_valid - one-cycle pulse on each newly accepted press
//   key_held  - high while the accepted key is still down (PRESSED/RELEASE)
module keypad_scan #(
  parameter int SCAN_DIV = 4,
  parameter int DEB_CNT  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_MAX   = BW'(DEB_CNT - 1);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [3:0]    r1, rs;
  logic [DW-1:0] dwell, dwell_n;
  logic [BW-1:0] deb, deb_n;
  logic [1:0]    col_idx, col_idx_n;
  logic [1:0]    row_idx, row_idx_n;
  logic [1:0]    low_row;
  logic          row_on;
  logic          accept;

  // Row synchronizer; idle (all released) value is all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1 <= 4'b1111;
      rs <= 4'b1111;
    end else begin
      r1 <= row;
      rs <= r1;
    end
  end

  // Lowest-index low row wins when several keys share the driven column.
  always_comb begin
    if (!rs[0])      low_row = 2'd0;
    else if (!rs[1]) low_row = 2'd1;
    else if (!rs[2]) low_row = 2'd2;
    else             low_row = 2'd3;
  end

  // Only the latched row is watched after detection; other rows are ignored.
  assign row_on = ~rs[row_idx];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_SCAN;
    else     state <= state_n;
  end

  // Next-state and datapath-next logic
  always_comb begin
    state_n   = state;
    dwell_n   = dwell;
    deb_n     = deb;
    col_idx_n = col_idx;
    row_idx_n = row_idx;
    accept    = 1'b0;
    unique case (state)
      S_SCAN: begin
        if (dwell == DWELL_MAX) begin
          dwell_n = '0;
          // Rows are only trusted at the end of the dwell, once the
          // synchronizer has settled on the current column.
          if (rs != 4'b1111) begin
            row_idx_n = low_row;
            deb_n     = '0;
            state_n   = S_DEBOUNCE;
          end else begin
            col_idx_n = col_idx + 2'd1;
          end
        end else begin
          dwell_n = dwell + DW'(1);
        end
      end
      S_DEBOUNCE: begin
        if (!row_on) begin
          // Bounce: rescan the same column from a fresh dwell.
          state_n = S_SCAN;
          dwell_n = '0;
        end else if (deb == DEB_MAX) begin
          state_n = S_PRESSED;
          accept  = 1'b1;
        end else begin
          deb_n = deb + BW'(1);
        end
      end
      S_PRESSED: begin
        if (!row_on) begin
          state_n = S_RELEASE;
          deb_n   = '0;
        end
      end
      S_RELEASE: begin
        if (row_on) begin
          state_n = S_PRESSED;
        end else if (deb == DEB_MAX) begin
          // Move past the released key so it is not immediately re-found.
          state_n   = S_SCAN;
          dwell_n   = '0;
          col_idx_n = col_idx + 2'd1;
        end else begin
          deb_n = deb + BW'(1);
        end
      end
      default: state_n = S_SCAN;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell     <= '0;
      deb       <= '0;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      key_code  <= 4'b0000;
      key_valid <= 1'b0;
    end else begin
      dwell     <= dwell_n;
      deb       <= deb_n;
      col_idx   <= col_idx_n;
      row_idx   <= row_idx_n;
      key_valid <= accept;
      if (accept) key_code <= {row_idx, col_idx};
    end
  end

  // Output logic
  always_comb begin
    col      = ~(4'b0001 << col_idx);
    key_held = (state == S_PRESSED) || (state == S_RELEASE);
  end

endmodule
